// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: status codes, register IDs,
// FSM state encoding and status helpers.
package writeback_stage_pkg;

    localparam int unsigned NREGS = 15;
    localparam int unsigned XLEN  = 64;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        STOP = 1'b1
    } wb_state_e;

    // Undefined status codes 5-7 are reported as an invalid instruction.
    function automatic logic [2:0] stat_norm(input logic [2:0] s);
        return (s > SINS) ? SINS : s;
    endfunction

    function automatic logic stat_stops(input logic [2:0] s);
        logic [2:0] n;
        n = stat_norm(s);
        return (n == SHLT) || (n == SADR) || (n == SINS);
    endfunction

endpackage

// File: rtl/writeback_stage_regfile15x64.sv
// 15 x 64-bit register file: two combinational read ports, two write ports,
// port M wins when both ports target the same register.
module regfile15x64
    import writeback_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_e_i,
    input  logic [3:0]           dst_e_i,
    input  logic [XLEN-1:0]      val_e_i,
    input  logic                 we_m_i,
    input  logic [3:0]           dst_m_i,
    input  logic [XLEN-1:0]      val_m_i,
    input  logic [3:0]           src_a_i,
    input  logic [3:0]           src_b_i,
    output logic [XLEN-1:0]      rval_a_o,
    output logic [XLEN-1:0]      rval_b_o
);

    logic [XLEN-1:0] rf_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (we_m_i && (dst_m_i == 4'(i))) begin
                    rf_q[i] <= val_m_i;
                end else if (we_e_i && (dst_e_i == 4'(i))) begin
                    rf_q[i] <= val_e_i;
                end
            end
        end
    end

    // No write bypass: reads always see the array as of the last edge.
    always_comb begin
        rval_a_o = '0;
        rval_b_o = '0;
        if (src_a_i != RNONE) begin
            rval_a_o = rf_q[src_a_i];
        end
        if (src_b_i != RNONE) begin
            rval_b_o = rf_q[src_b_i];
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: register file writes, RUN/STOP status FSM and, when
// WB_RETIRE_CNT_EN is defined, a 64-bit retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      W_stat,
    input  logic [3:0]      W_icode,
    input  logic [63:0]     W_valE,
    input  logic [63:0]     W_valM,
    input  logic [3:0]      W_dstE,
    input  logic [3:0]      W_dstM,
    input  logic [3:0]      d_srcA,
    input  logic [3:0]      d_srcB,
    output logic [63:0]     d_rvalA,
    output logic [63:0]     d_rvalB,
    output logic            W_stall,
    output logic [2:0]      cpu_stat,
    output logic            halted,
    output logic [63:0]     retire_cnt
);

    wb_state_e  state_q, state_d;
    logic [2:0] cpu_stat_q, cpu_stat_d;
    logic       halted_q, halted_d;
    logic       stall_q, stall_d;
    logic       retire;
    logic       icode_unused;

    // The opcode is carried through the W register but not needed here.
    assign icode_unused = ^W_icode;

    assign retire = (state_q == RUN) && (W_stat == SAOK) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cpu_stat_q <= SAOK;
            halted_q   <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
            halted_q   <= halted_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        halted_d   = halted_q;
        stall_d    = stall_q;
        unique case (state_q)
            RUN: begin
                cpu_stat_d = SAOK;
                halted_d   = 1'b0;
                stall_d    = 1'b0;
                if (stat_stops(W_stat)) begin
                    state_d    = STOP;
                    cpu_stat_d = stat_norm(W_stat);
                    halted_d   = 1'b1;
                    stall_d    = 1'b1;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    regfile15x64 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_e_i   (retire),
        .dst_e_i  (W_dstE),
        .val_e_i  (W_valE),
        .we_m_i   (retire),
        .dst_m_i  (W_dstM),
        .val_m_i  (W_valM),
        .src_a_i  (d_srcA),
        .src_b_i  (d_srcB),
        .rval_a_o (d_rvalA),
        .rval_b_o (d_rvalB)
    );

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = '0;
`endif

    assign cpu_stat = cpu_stat_q;
    assign halted   = halted_q;
    assign W_stall  = stall_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; retire_cnt expectations
// follow WB_RETIRE_CNT_EN.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic        W_stall;
    logic [2:0]  cpu_stat;
    logic        halted;
    logic [63:0] retire_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] exp_cnt = 64'd0;

    writeback_stage dut (
        .clk        (clk),
        .rst        (rst),
        .W_stat     (W_stat),
        .W_icode    (W_icode),
        .W_valE     (W_valE),
        .W_valM     (W_valM),
        .W_dstE     (W_dstE),
        .W_dstM     (W_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .d_rvalA    (d_rvalA),
        .d_rvalB    (d_rvalB),
        .W_stall    (W_stall),
        .cpu_stat   (cpu_stat),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        W_stat = st;
        W_dstE = de;
        W_valE = ve;
        W_dstM = dm;
        W_valM = vm;
    endtask

    task automatic read(input logic [3:0] a, input logic [3:0] b);
        d_srcA = a;
        d_srcB = b;
        #1;
    endtask

    function automatic logic [63:0] exp_ret();
`ifdef WB_RETIRE_CNT_EN
        return exp_cnt;
`else
        return 64'd0;
`endif
    endfunction

    task automatic check_status(input string tag, input logic [2:0] st, input logic h);
        check({tag, "_stat"}, 64'(cpu_stat), 64'(st));
        check({tag, "_halted"}, 64'(halted), 64'(h));
        check({tag, "_stall"}, 64'(W_stall), 64'(h));
    endtask

    initial begin
        W_icode = 4'h0;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;

        // Reset while an SAOK write is presented: reset must win.
        rst = 1'b1;
        drive(3'd1, 4'd0, 64'hDEAD, 4'hF, 64'h0);
        step();
        rst = 1'b0;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd0, 4'hF);
        check_status("reset", 3'd1, 1'b0);
        check("reset_r0", d_rvalA, 64'd0);
        check("reset_rnone", d_rvalB, 64'd0);
        check("reset_cnt", retire_cnt, exp_ret());

        // Simple valE write to register 0.
        drive(3'd1, 4'd0, 64'd5, 4'hF, 64'h0);
        step(); exp_cnt++;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd0, 4'hF);
        check("wrE_r0", d_rvalA, 64'd5);
        check("wrE_cnt", retire_cnt, exp_ret());

        // Same destination on both ports: valM wins; no bypass before the edge.
        drive(3'd1, 4'd4, 64'd1, 4'd4, 64'd2);
        read(4'hF, 4'd4);
        check("nobypass_r4", d_rvalB, 64'd0);
        step(); exp_cnt++;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'hF, 4'd4);
        check("prioM_r4", d_rvalB, 64'd2);

        // Independent E and M writes, including top register 14.
        drive(3'd1, 4'd7, 64'h77, 4'd14, 64'hFEDC_BA98_7654_3210);
        step(); exp_cnt++;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd7, 4'd14);
        check("dual_r7", d_rvalA, 64'h77);
        check("dual_r14", d_rvalB, 64'hFEDC_BA98_7654_3210);

        // SAOK with no destinations: nothing written, counter still advances.
        drive(3'd1, 4'hF, 64'd99, 4'hF, 64'd98);
        step(); exp_cnt++;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd0, 4'd4);
        check("none_r0", d_rvalA, 64'd5);
        check("none_r4", d_rvalB, 64'd2);
        check("none_cnt", retire_cnt, exp_ret());

        // Bubble: no write, no state change, no retire.
        drive(3'd0, 4'd2, 64'd3, 4'hF, 64'h0);
        step();
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd2, 4'hF);
        check("bub_r2", d_rvalA, 64'd0);
        check_status("bub", 3'd1, 1'b0);
        check("bub_cnt", retire_cnt, exp_ret());

        // SADR: faulting instruction does not write; status latches next cycle.
        drive(3'd3, 4'd3, 64'd9, 4'hF, 64'h0);
        read(4'd3, 4'hF);
        check_status("sadr_pre", 3'd1, 1'b0);
        step();
        drive(3'd1, 4'd3, 64'h33, 4'd5, 64'h55);
        read(4'd3, 4'd5);
        check("sadr_r3", d_rvalA, 64'd0);
        check_status("sadr", 3'd3, 1'b1);
        step();
        drive(3'd2, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd3, 4'd5);
        check("stop_r3", d_rvalA, 64'd0);
        check("stop_r5", d_rvalB, 64'd0);
        check_status("stop_hold", 3'd3, 1'b1);
        check("stop_cnt", retire_cnt, exp_ret());

        // Reset out of STOP clears registers, status and counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 64'd0;
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd0, 4'd14);
        check_status("rst1", 3'd1, 1'b0);
        check("rst1_r0", d_rvalA, 64'd0);
        check("rst1_r14", d_rvalB, 64'd0);
        check("rst1_cnt", retire_cnt, exp_ret());

        // Undefined status code 6 stops as SINS.
        drive(3'd6, 4'd1, 64'd11, 4'hF, 64'h0);
        step();
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd1, 4'hF);
        check("code6_r1", d_rvalA, 64'd0);
        check_status("code6", 3'd4, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Write, halt via SHLT, then reset.
        drive(3'd1, 4'd6, 64'h66, 4'hF, 64'h0);
        step(); exp_cnt++;
        drive(3'd2, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd6, 4'hF);
        check("pre_hlt_r6", d_rvalA, 64'h66);
        step();
        drive(3'd0, 4'hF, 64'h0, 4'hF, 64'h0);
        read(4'd6, 4'hF);
        check_status("hlt", 3'd2, 1'b1);
        check("hlt_cnt", retire_cnt, exp_ret());
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 64'd0;
        read(4'd6, 4'd0);
        check_status("rst2", 3'd1, 1'b0);
        check("rst2_r6", d_rvalA, 64'd0);
        check("rst2_r0", d_rvalB, 64'd0);
        check("rst2_cnt", retire_cnt, exp_ret());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
